uart_bus_bridge: RTL and testbench



---
 rtl/uart_bridge_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_bus_bridge.sv | 163 ++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX FSM state type
// for the UART bus bridge.
package uart_bridge_pkg;
   localparam logic [3:0] UART_REG_DATA   = 4'h0;
   localparam logic [3:0] UART_REG_STATUS = 4'h4;
   localparam logic [3:0] UART_REG_CTRL   = 4'h8;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_RX_OVF   = 4;
   localparam int ST_TX_OVF   = 5;
   localparam int ST_BUSY     = 6;

   localparam int CTRL_RX_IRQ_EN  = 0;
   localparam int CTRL_TX_IRQ_EN  = 1;
   localparam int CTRL_RX_OVF_CLR = 2;
   localparam int CTRL_TX_OVF_CLR = 3;

   typedef enum logic {TX_IDLE = 1'b0, TX_WAIT = 1'b1} uart_tx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [AW:0]      r_cnt;
   logic             w_push, w_pop;

   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= din;
   end

   assign full  = (r_cnt == (AW+1)'(DEPTH));
   assign empty = (r_cnt == '0);
   assign count = r_cnt;
   assign head  = r_mem[r_rp];
endmodule

// File: rtl/uart_bus_bridge.sv
// Memory-mapped front end for the UART byte engine: TX FIFO + send FSM, RX drain.
// Define UART_BRIDGE_RX_FIFO_EN for an RX_DEPTH FIFO; otherwise RX is a one-byte holding register.
module uart_bus_bridge
   import uart_bridge_pkg::*;
#(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  bus_addr,
   input  logic        bus_wr,
   input  logic        bus_rd,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        irq,
   output logic [7:0]  uart_send_data,
   output logic        uart_send,
   input  logic        uart_send_busy,
   input  logic [7:0]  uart_rev_data,
   input  logic        uart_rev_data_valid,
   output logic        uart_rev_data_invalid
);
   localparam int TXCW = $clog2(TX_DEPTH) + 1;
   localparam int RXCW = $clog2(RX_DEPTH) + 1;

   logic            w_wr_data, w_rd_data, w_wr_ctrl;
   logic            w_tx_full, w_tx_empty, w_tx_pop;
   logic [TXCW-1:0] w_tx_cnt;
   logic [7:0]      w_tx_head;
   logic            w_rx_full, w_rx_empty, w_rx_pop;
   logic [RXCW-1:0] w_rx_cnt;
   logic [7:0]      w_rx_head;
   logic [31:0]     w_status, w_rdata;
   logic            w_unused;

   uart_tx_state_t  r_state, w_state_nxt;
   logic            r_seen_busy;
   logic            r_rx_irq_en, r_tx_irq_en, r_rx_ovf, r_tx_ovf;
   logic [31:0]     r_rdata;
   logic            r_irq, r_send;
   logic [7:0]      r_send_data;

   assign w_wr_data = bus_wr & (bus_addr == UART_REG_DATA);
   assign w_wr_ctrl = bus_wr & (bus_addr == UART_REG_CTRL);
   assign w_rd_data = bus_rd & (bus_addr == UART_REG_DATA);
   assign w_rx_pop  = w_rd_data & ~w_rx_empty;
   assign w_unused  = ^{bus_wdata[31:8], w_tx_cnt, w_tx_full & 1'b0};

   uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(w_wr_data), .pop(w_tx_pop), .din(bus_wdata[7:0]),
      .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_cnt), .head(w_tx_head)
   );

   // The engine drops valid on the edge after our ack, so each byte is seen once.
   assign uart_rev_data_invalid = uart_rev_data_valid;

`ifdef UART_BRIDGE_RX_FIFO_EN
   uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(uart_rev_data_valid), .pop(w_rd_data), .din(uart_rev_data),
      .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_cnt), .head(w_rx_head)
   );
`else
   logic       r_rx_vld;
   logic [7:0] r_rx_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_vld  <= 1'b0;
         r_rx_data <= '0;
      end else if (uart_rev_data_valid && (!r_rx_vld || w_rx_pop)) begin
         r_rx_vld  <= 1'b1;
         r_rx_data <= uart_rev_data;
      end else if (w_rx_pop) begin
         r_rx_vld  <= 1'b0;
      end
   end

   assign w_rx_empty = ~r_rx_vld;
   assign w_rx_full  = r_rx_vld;
   assign w_rx_cnt   = RXCW'(r_rx_vld);
   assign w_rx_head  = r_rx_data;
`endif

   // TX FSM: WAIT exits only after busy has been seen high and then low again.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= TX_IDLE;
         r_seen_busy <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_seen_busy <= (r_state == TX_WAIT) & (r_seen_busy | uart_send_busy);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TX_IDLE: if (!w_tx_empty && !uart_send_busy) w_state_nxt = TX_WAIT;
         TX_WAIT: if (r_seen_busy && !uart_send_busy) w_state_nxt = TX_IDLE;
         default: w_state_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      w_tx_pop = (r_state == TX_IDLE) & ~w_tx_empty & ~uart_send_busy;
   end

   always_comb begin
      w_status = '0;
      w_status[ST_TX_FULL]  = w_tx_full;
      w_status[ST_TX_EMPTY] = w_tx_empty;
      w_status[ST_RX_EMPTY] = w_rx_empty;
      w_status[ST_RX_FULL]  = w_rx_full;
      w_status[ST_RX_OVF]   = r_rx_ovf;
      w_status[ST_TX_OVF]   = r_tx_ovf;
      w_status[ST_BUSY]     = uart_send_busy;
      w_status[15:8]        = 8'(w_rx_cnt);
   end

   always_comb begin
      w_rdata = '0;
      case (bus_addr)
         UART_REG_DATA:   w_rdata = {24'b0, w_rx_empty ? 8'h00 : w_rx_head};
         UART_REG_STATUS: w_rdata = w_status;
         UART_REG_CTRL:   w_rdata = {30'b0, r_tx_irq_en, r_rx_irq_en};
         default:         w_rdata = '0;
      endcase
   end

   // Sticky flags: a new overflow in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata     <= '0;
         r_rx_irq_en <= 1'b0;
         r_tx_irq_en <= 1'b0;
         r_rx_ovf    <= 1'b0;
         r_tx_ovf    <= 1'b0;
         r_irq       <= 1'b0;
         r_send      <= 1'b0;
         r_send_data <= '0;
      end else begin
         if (bus_rd) r_rdata <= w_rdata;
         if (w_wr_ctrl) begin
            r_rx_irq_en <= bus_wdata[CTRL_RX_IRQ_EN];
            r_tx_irq_en <= bus_wdata[CTRL_TX_IRQ_EN];
         end
         r_rx_ovf <= (uart_rev_data_valid & w_rx_full & ~w_rx_pop) |
                     (r_rx_ovf & ~(w_wr_ctrl & bus_wdata[CTRL_RX_OVF_CLR]));
         r_tx_ovf <= (w_wr_data & w_tx_full & ~w_tx_pop) |
                     (r_tx_ovf & ~(w_wr_ctrl & bus_wdata[CTRL_TX_OVF_CLR]));
         r_irq    <= (r_rx_irq_en & ~w_rx_empty) |
                     (r_tx_irq_en & w_tx_empty & (r_state == TX_IDLE));
         r_send   <= w_tx_pop;
         if (w_tx_pop) r_send_data <= w_tx_head;
      end
   end

   assign bus_rdata      = r_rdata;
   assign irq            = r_irq;
   assign uart_send      = r_send;
   assign uart_send_data = r_send_data;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus queues expected bytes/read data,
// a negedge monitor compares them as the DUT presents uart_send and bus_rdata.
module tb_uart_bus_bridge;
`ifdef UART_BRIDGE_RX_FIFO_EN
   localparam int RXD = 16;
`else
   localparam int RXD = 1;
`endif

   logic        clk, rst;
   logic [3:0]  bus_addr;
   logic        bus_wr, bus_rd;
   logic [31:0] bus_wdata, bus_rdata;
   logic        irq;
   logic [7:0]  uart_send_data;
   logic        uart_send, uart_send_busy;
   logic [7:0]  uart_rev_data;
   logic        uart_rev_data_valid, uart_rev_data_invalid;

   uart_bus_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq),
      .uart_send_data(uart_send_data), .uart_send(uart_send), .uart_send_busy(uart_send_busy),
      .uart_rev_data(uart_rev_data), .uart_rev_data_valid(uart_rev_data_valid),
      .uart_rev_data_invalid(uart_rev_data_invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          inv_cnt = 0;
   logic [7:0]  tx_q[$];
   logic [31:0] rd_q[$];
   logic        rd_seen = 1'b0;
   logic [31:0] mon_exp;
   logic [7:0]  mon_tx;

   // Engine model: busy for 4 cycles after each send; eng_hold forces busy.
   logic [3:0]  eng_cnt;
   logic        eng_hold;
   always @(posedge clk) begin
      if (rst)                eng_cnt <= 4'd0;
      else if (uart_send)     eng_cnt <= 4'd4;
      else if (eng_cnt != 0)  eng_cnt <= eng_cnt - 4'd1;
   end
   assign uart_send_busy = (eng_cnt != 4'd0) | eng_hold;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rd_seen) begin
         total++;
         if (rd_q.size() == 0) begin
            bad++;
            $display("FAIL rdata: got %h expected no read response", bus_rdata);
         end else begin
            mon_exp = rd_q.pop_front();
            if (bus_rdata !== mon_exp) begin
               bad++;
               $display("FAIL rdata: got %h expected %h", bus_rdata, mon_exp);
            end
         end
      end
      rd_seen = bus_rd & ~rst;
      if (uart_send === 1'b1) begin
         total++;
         if (tx_q.size() == 0) begin
            bad++;
            $display("FAIL send: got byte %h expected no send", uart_send_data);
         end else begin
            mon_tx = tx_q.pop_front();
            if (uart_send_data !== mon_tx) begin
               bad++;
               $display("FAIL send: got %h expected %h", uart_send_data, mon_tx);
            end
         end
         chk("send_while_busy", {31'b0, uart_send_busy}, 32'd0);
      end
      if (uart_rev_data_invalid === 1'b1) inv_cnt++;
   end

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
      @(posedge clk); #1;
      bus_wr = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
      rd_q.push_back(exp);
      bus_addr = a; bus_rd = 1'b1;
      @(posedge clk); #1;
      bus_rd = 1'b0;
   endtask

   // Engine holds valid until it sees the ack, then drops it on that edge.
   task automatic rx_byte(input logic [7:0] b);
      logic acked;
      acked = 1'b0;
      uart_rev_data = b; uart_rev_data_valid = 1'b1;
      for (int k = 0; k < 8 && !acked; k++) begin
         @(negedge clk); acked = uart_rev_data_invalid;
         @(posedge clk); #1;
      end
      uart_rev_data_valid = 1'b0;
      chk("rx_ack", {31'b0, acked}, 32'd1);
   endtask

   task automatic wait_tx(input int budget);
      int n;
      n = 0;
      while (tx_q.size() != 0 && n < budget) begin
         @(posedge clk); n++;
      end
      #1;
      chk("tx_drain_left", tx_q.size(), 32'd0);
   endtask

   initial begin
      int inv0;
      rst = 1'b1; bus_addr = '0; bus_wr = 1'b0; bus_rd = 1'b0; bus_wdata = '0;
      uart_rev_data = '0; uart_rev_data_valid = 1'b0; eng_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", bus_rdata, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_send", {31'b0, uart_send}, 32'd0);
      chk("rst_send_data", {24'b0, uart_send_data}, 32'd0);
      chk("rst_rx_ack", {31'b0, uart_rev_data_invalid}, 32'd0);
      rst = 1'b0;
      bus_read(4'h4, 32'h06);
      bus_read(4'h8, 32'h00);
      bus_read(4'hC, 32'h00);
      bus_read(4'h0, 32'h00);

      // Three bytes through an idle engine
      tx_q.push_back(8'h41); bus_write(4'h0, 32'h41);
      tx_q.push_back(8'h42); bus_write(4'h0, 32'h42);
      tx_q.push_back(8'h43); bus_write(4'h0, 32'h43);
      wait_tx(200);
      repeat (10) @(posedge clk);
      #1;

      // Single RX byte, valid held until ack
      inv0 = inv_cnt;
      rx_byte(8'h5A);
      repeat (3) @(posedge clk);
      #1;
      chk("rx_ack_pulses", inv_cnt - inv0, 32'd1);
      bus_read(4'h0, 32'h5A);
      bus_read(4'h4, 32'h06);

      // Fill RX, overflow, clear, then simultaneous pop+push on full
      for (int i = 0; i < RXD; i++) rx_byte(8'h80 + 8'(i));
      rx_byte(8'h99);
      bus_read(4'h4, 32'h1A | (RXD << 8));
      bus_write(4'h8, 32'h4);
      bus_read(4'h4, 32'h0A | (RXD << 8));
      rd_q.push_back(32'h80);
      bus_addr = 4'h0; bus_rd = 1'b1; uart_rev_data = 8'h77; uart_rev_data_valid = 1'b1;
      @(posedge clk); #1;
      bus_rd = 1'b0; uart_rev_data_valid = 1'b0;
      bus_read(4'h4, 32'h0A | (RXD << 8));
      for (int i = 1; i < RXD; i++) bus_read(4'h0, 32'h80 + i);
      bus_read(4'h0, 32'h77);
      bus_read(4'h4, 32'h06);

      // Interrupt behaviour and CTRL readback
      bus_write(4'h8, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      chk("irq_rx_idle", {31'b0, irq}, 32'd0);
      rx_byte(8'h11);
      chk("irq_rx_push_edge", {31'b0, irq}, 32'd0);
      @(posedge clk); #1;
      chk("irq_rx_rise", {31'b0, irq}, 32'd1);
      bus_read(4'h0, 32'h11);
      chk("irq_rx_pop_edge", {31'b0, irq}, 32'd1);
      @(posedge clk); #1;
      chk("irq_rx_fall", {31'b0, irq}, 32'd0);
      bus_write(4'h8, 32'h2);
      repeat (2) @(posedge clk);
      #1;
      chk("irq_tx_empty", {31'b0, irq}, 32'd1);
      bus_write(4'h8, 32'hF);
      bus_read(4'h8, 32'h3);
      bus_write(4'h8, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("irq_off", {31'b0, irq}, 32'd0);

      // 17 writes into a held engine: 16 queued, one dropped
      eng_hold = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) tx_q.push_back(8'h10 + 8'(i));
         bus_write(4'h0, 32'h10 + i);
      end
      bus_read(4'h4, 32'h65);
      bus_write(4'h8, 32'h8);
      bus_read(4'h4, 32'h45);
      eng_hold = 1'b0;
      wait_tx(400);
      repeat (10) @(posedge clk);
      #1;

      // Reset while in WAIT with bytes queued
      bus_write(4'h8, 32'h3);
      tx_q.push_back(8'h55); bus_write(4'h0, 32'h55);
      wait_tx(50);
      eng_hold = 1'b1;
      for (int i = 0; i < 5; i++) bus_write(4'h0, 32'h60 + i);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1; eng_hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_irq", {31'b0, irq}, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      bus_read(4'h4, 32'h06);
      bus_read(4'h8, 32'h0);
      chk("rst_mid_irq_late", {31'b0, irq}, 32'd0);
      chk("rst_mid_send_data", {24'b0, uart_send_data}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rd_q_left", rd_q.size(), 32'd0);
      chk("tx_q_left", tx_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
